// File: rtl/speck_decrypt_core.sv
// Iterative SPECK128/128 decryption: expands the key into a local round-key file,
// then runs one inverse round per clock in reverse key order.
module speck_decrypt_core #(
  parameter int NR_ROUNDS = 32,
  parameter int ALPHA     = 8,
  parameter int BETA      = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         signal_start,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic [127:0] plaintext,
  output logic         finished,
  output logic         busy,
  output logic [3:0]   state_response
);

  localparam int IW = (NR_ROUNDS > 2) ? $clog2(NR_ROUNDS) : 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    EXPAND  = 4'd1,
    DECRYPT = 4'd2,
    DONE    = 4'd3
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   rk_q [NR_ROUNDS];
  logic [63:0]   l_q, x_q, y_q;
  logic [IW-1:0] idx_q;
  logic [127:0]  pt_q;

  logic [63:0]   rk_cur, l_nxt, rk_nxt, x_nxt, y_nxt;
  logic          last_expand, last_round;

  function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // idx_q is the schedule index i during EXPAND and the round index r during DECRYPT
  assign rk_cur      = rk_q[idx_q];
  assign l_nxt       = (ror64(l_q, ALPHA) + rk_cur) ^ 64'(idx_q);
  assign rk_nxt      = rol64(rk_cur, BETA) ^ l_nxt;
  assign y_nxt       = ror64(x_q ^ y_q, BETA);
  assign x_nxt       = rol64((x_q ^ rk_cur) - y_nxt, ALPHA);
  assign last_expand = (idx_q == IW'(NR_ROUNDS - 2));
  assign last_round  = (idx_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = signal_start ? EXPAND : IDLE;
      EXPAND:  state_d = last_expand ? DECRYPT : EXPAND;
      DECRYPT: state_d = last_round ? DONE : DECRYPT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    finished = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE:    busy = 1'b0;
      DONE:    finished = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NR_ROUNDS; j++) rk_q[j] <= '0;
      l_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      idx_q <= '0;
      pt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (signal_start) begin
            rk_q[0] <= key[127:64];
            l_q     <= key[63:0];
            x_q     <= ciphertext[127:64];
            y_q     <= ciphertext[63:0];
            idx_q   <= '0;
          end
        end
        EXPAND: begin
          l_q                    <= l_nxt;
          rk_q[idx_q + IW'(1)]   <= rk_nxt;
          idx_q                  <= last_expand ? IW'(NR_ROUNDS - 1) : idx_q + IW'(1);
        end
        DECRYPT: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          if (last_round) pt_q  <= {x_nxt, y_nxt};
          else            idx_q <= idx_q - IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign plaintext      = pt_q;
  assign state_response = state_q;

endmodule

// File: tb/tb_speck_decrypt_core.sv
// Directed bench for speck_decrypt_core: published vector, encrypt/decrypt round
// trips, start re-pulses, mid-job reset and back-to-back jobs.
module tb_speck_decrypt_core;

  localparam int NR = 32;
  localparam logic [127:0] K1 = 128'h07060504030201000f0e0d0c0b0a0908;
  localparam logic [127:0] C1 = 128'ha65d9851797832657860fedf5c570d18;
  localparam logic [127:0] P1 = 128'h6c617669757165207469206564616d20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         signal_start;
  logic [127:0] key, ciphertext, plaintext;
  logic         finished, busy;
  logic [3:0]   state_response;

  int vectors     = 0;
  int miscompares = 0;
  int fin_cnt     = 0;

  logic [127:0] p, k, pt, c;
  int lat, cyc, base, nfin, idle;
  int t [3];

  always #5 clk = ~clk;

  speck_decrypt_core #(.NR_ROUNDS(NR), .ALPHA(8), .BETA(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .signal_start   (signal_start),
    .key            (key),
    .ciphertext     (ciphertext),
    .plaintext      (plaintext),
    .finished       (finished),
    .busy           (busy),
    .state_response (state_response)
  );

  always @(negedge clk) if (finished === 1'b1) fin_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference encryptor (forward cipher and key schedule, fixed ALPHA=8, BETA=3)
  function automatic logic [127:0] speck_enc(input logic [127:0] kk, input logic [127:0] pp);
    logic [63:0] a, b, x, y;
    a = kk[127:64]; b = kk[63:0]; x = pp[127:64]; y = pp[63:0];
    for (int i = 0; i < NR; i++) begin
      x = ({x[7:0], x[63:8]} + y) ^ a;
      y = {y[60:0], y[63:61]} ^ x;
      b = ({b[7:0], b[63:8]} + a) ^ 64'(i);
      a = {a[60:0], a[63:61]} ^ b;
    end
    return {x, y};
  endfunction

  task automatic run_job(input logic [127:0] kk, input logic [127:0] cc,
                         output logic [127:0] res, output int n);
    key = kk; ciphertext = cc; signal_start = 1'b1;
    tick;
    signal_start = 1'b0;
    key = ~kk; ciphertext = ~cc;
    n = 0;
    while (finished !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    res = plaintext;
    if (finished !== 1'b1) expect_eq("job_timeout", {127'b0, finished}, 128'd1);
  endtask

  initial begin
    rst_n = 1'b0; signal_start = 1'b0; key = '0; ciphertext = '0;
    #12;
    expect_eq("reset_pt", plaintext, 128'd0);
    expect_eq("reset_fin_busy", {126'b0, finished, busy}, 128'd0);
    expect_eq("reset_state", {124'b0, state_response}, 128'd0);
    tick; rst_n = 1'b1; tick;

    // 1: published vector and latency
    run_job(K1, C1, p, lat);
    expect_eq("t1_pt", p, P1);
    expect_eq("t1_latency", 128'(lat), 128'd63);
    expect_eq("t1_busy_in_done", {127'b0, busy}, 128'd1);
    tick;
    expect_eq("t1_pulse_end", {126'b0, finished, busy}, 128'd0);
    repeat (4) tick;
    expect_eq("t1_pt_hold", plaintext, P1);

    // 2: encrypt/decrypt round trips
    for (int n = 0; n < 200; n++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      c  = speck_enc(k, pt);
      run_job(k, c, p, lat);
      expect_eq($sformatf("t2_rt%0d", n), p, pt);
      tick;
    end

    // 3: start re-pulsed mid-job with other inputs
    base = fin_cnt;
    key = K1; ciphertext = C1; signal_start = 1'b1;
    tick;
    signal_start = 1'b0;
    cyc = 0;
    while (finished !== 1'b1 && cyc < 200) begin
      if (cyc == 5 || cyc == 40) begin
        signal_start = 1'b1; key = 128'h1; ciphertext = 128'hdeadbeef;
      end else signal_start = 1'b0;
      tick;
      cyc++;
    end
    signal_start = 1'b0;
    expect_eq("t3_pt", plaintext, P1);
    expect_eq("t3_latency", 128'(cyc), 128'd63);
    repeat (5) tick;
    expect_eq("t3_one_pulse", 128'(fin_cnt - base), 128'd1);
    expect_eq("t3_idle", {124'b0, state_response}, 128'd0);

    // 4: reset during DECRYPT
    key = K1; ciphertext = C1; signal_start = 1'b1;
    tick;
    signal_start = 1'b0;
    expect_eq("t4_expand_state", {124'b0, state_response}, 128'd1);
    repeat (31) tick;
    repeat (10) tick;
    expect_eq("t4_decrypt_state", {124'b0, state_response}, 128'd2);
    expect_eq("t4_pt_before_rst", plaintext, P1);
    base = fin_cnt;
    #2 rst_n = 1'b0;
    #1;
    expect_eq("t4_rst_pt", plaintext, 128'd0);
    expect_eq("t4_rst_fin_busy", {126'b0, finished, busy}, 128'd0);
    expect_eq("t4_rst_state", {124'b0, state_response}, 128'd0);
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    expect_eq("t4_no_pulse", 128'(fin_cnt - base), 128'd0);
    run_job(K1, C1, p, lat);
    expect_eq("t4_after_rst_pt", p, P1);
    tick;

    // 5: all-zero key and ciphertext, checked by re-encrypting the result
    run_job(128'd0, 128'd0, p, lat);
    expect_eq("t5_zero_roundtrip", speck_enc(128'd0, p), 128'd0);
    expect_eq("t5_latency", 128'(lat), 128'd63);
    tick;

    // 6: start held high for three jobs
    key = K1; ciphertext = C1; signal_start = 1'b1;
    cyc = 0; nfin = 0; idle = 0;
    while (nfin < 3 && cyc < 400) begin
      tick;
      cyc++;
      if (finished === 1'b1) begin
        t[nfin] = cyc;
        expect_eq($sformatf("t6_pt%0d", nfin), plaintext, P1);
        nfin++;
        if (nfin == 3) signal_start = 1'b0;
      end else if (busy === 1'b0 && nfin > 0) idle++;
    end
    signal_start = 1'b0;
    expect_eq("t6_pulses", 128'(nfin), 128'd3);
    if (nfin == 3) begin
      expect_eq("t6_first", 128'(t[0]), 128'd64);
      expect_eq("t6_gap1", 128'(t[1] - t[0]), 128'd65);
      expect_eq("t6_gap2", 128'(t[2] - t[1]), 128'd65);
    end
    expect_eq("t6_idle_cycles", 128'(idle), 128'd2);
    repeat (2) tick;
    expect_eq("t6_final_state", {124'b0, state_response}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
